// File: rtl/mul_share_arbiter_if.sv
// ---------------------------------------------------------------------------
// mul_share_arbiter_if
// Bundles the two requester issue channels and the two response channels of
// the shared multiplier.
//   reqN_valid/ready   : issue handshake for requester N (accept = valid & ready)
//   reqN_a/b           : operands, WIDTH bits
//   reqN_signed        : 1 = two's-complement operands, 0 = unsigned
//   respN_valid        : one-cycle pulse, respN_result carries a new product
//   respN_result       : 2*WIDTH-bit product, holds its value between pulses
// Modports: master = the requesting lanes, slave = the arbiter.
// ---------------------------------------------------------------------------
interface mul_share_arbiter_if #(
   parameter int WIDTH = 16
);
   logic                 req0_valid;
   logic                 req0_ready;
   logic [WIDTH-1:0]     req0_a;
   logic [WIDTH-1:0]     req0_b;
   logic                 req0_signed;
   logic                 req1_valid;
   logic                 req1_ready;
   logic [WIDTH-1:0]     req1_a;
   logic [WIDTH-1:0]     req1_b;
   logic                 req1_signed;
   logic                 resp0_valid;
   logic [2*WIDTH-1:0]   resp0_result;
   logic                 resp1_valid;
   logic [2*WIDTH-1:0]   resp1_result;

   modport master (
      output req0_valid, req0_a, req0_b, req0_signed,
      output req1_valid, req1_a, req1_b, req1_signed,
      input  req0_ready, req1_ready,
      input  resp0_valid, resp0_result, resp1_valid, resp1_result
   );

   modport slave (
      input  req0_valid, req0_a, req0_b, req0_signed,
      input  req1_valid, req1_a, req1_b, req1_signed,
      output req0_ready, req1_ready,
      output resp0_valid, resp0_result, resp1_valid, resp1_result
   );
endinterface

// File: rtl/mul_share_arbiter.sv
// ---------------------------------------------------------------------------
// mul_array
// Combinational unsigned WIDTH x WIDTH -> 2*WIDTH multiplier.
//   a_i, b_i : unsigned operands
//   p_o      : unsigned product
// BEHAVIORAL=1 uses the '*' operator; otherwise a partial-product array is
// summed row by row, with an explicit bit-serial ripple-carry adder per row
// when RIPPLE_CARRY=1.
// ---------------------------------------------------------------------------
module mul_array #(
   parameter int WIDTH        = 16,
   parameter int BEHAVIORAL   = 0,
   parameter int RIPPLE_CARRY = 1
) (
   input  logic [WIDTH-1:0]   a_i,
   input  logic [WIDTH-1:0]   b_i,
   output logic [2*WIDTH-1:0] p_o
);
   localparam int PW = 2 * WIDTH;

   if (BEHAVIORAL != 0) begin : g_behav
      assign p_o = PW'(a_i) * PW'(b_i);
   end else begin : g_array
      logic [PW-1:0] pp [WIDTH];
      logic [PW-1:0] acc;

      // Row gi is A shifted to bit gi, gated by B[gi].
      for (genvar gi = 0; gi < WIDTH; gi++) begin : g_pp
         assign pp[gi] = b_i[gi] ? (PW'(a_i) << gi) : '0;
      end

      always_comb begin
         logic          carry;
         logic [PW-1:0] sum;
         acc   = '0;
         carry = 1'b0;
         sum   = '0;
         for (int r = 0; r < WIDTH; r++) begin
            if (RIPPLE_CARRY != 0) begin
               carry = 1'b0;
               for (int j = 0; j < PW; j++) begin
                  sum[j] = acc[j] ^ pp[r][j] ^ carry;
                  carry  = (acc[j] & pp[r][j]) | (carry & (acc[j] ^ pp[r][j]));
               end
               acc = sum;
            end else begin
               acc = acc + pp[r];
            end
         end
      end

      assign p_o = acc;
   end
endmodule

// ---------------------------------------------------------------------------
// mul_share_arbiter
// Round-robin shares one mul_array between two requesters. Accepted ops flow
// through an operand register (stage 1) and a product register (stage 2);
// the response appears two cycles after the accept on the winner's port.
// Signed ops are run as unsigned magnitudes and the product is negated when
// the operand signs differ.
//   clk  : clock, all state on the rising edge
//   rst  : asynchronous active-high reset
//   bus  : slave side of mul_share_arbiter_if (issue + response channels)
// ---------------------------------------------------------------------------
module mul_share_arbiter #(
   parameter int WIDTH = 16
) (
   input  logic                clk,
   input  logic                rst,
   mul_share_arbiter_if.slave  bus
);
   localparam int PW = 2 * WIDTH;

   // Returns |v| as an unsigned WIDTH-bit value. The most negative input
   // wraps to 2^(WIDTH-1), which is the correct unsigned magnitude.
   function automatic logic [WIDTH-1:0] magnitude(input logic [WIDTH-1:0] v,
                                                  input logic             s);
      return (s && v[WIDTH-1]) ? (~v + WIDTH'(1)) : v;
   endfunction

   logic             last_grant_q, last_grant_d;
   logic             grant0, grant1;
   logic             s1_valid_q, s1_valid_d;
   logic             s1_tag_q, s1_tag_d;
   logic             s1_neg_q, s1_neg_d;
   logic [WIDTH-1:0] s1_a_q, s1_a_d;
   logic [WIDTH-1:0] s1_b_q, s1_b_d;
   logic [PW-1:0]    prod_u;
   logic [PW-1:0]    prod_s;
   logic             resp0_valid_q, resp1_valid_q;
   logic [PW-1:0]    resp0_result_q, resp1_result_q;

   // On contention the requester that did not win last time gets the grant.
   // last_grant resets to 1 so requester 0 wins the first contention.
   assign grant0 = bus.req0_valid & (~bus.req1_valid | last_grant_q);
   assign grant1 = bus.req1_valid & (~bus.req0_valid | ~last_grant_q);

   assign bus.req0_ready = grant0;
   assign bus.req1_ready = grant1;

   always_comb begin
      logic [WIDTH-1:0] sel_a;
      logic [WIDTH-1:0] sel_b;
      logic             sel_s;
      sel_a        = grant1 ? bus.req1_a      : bus.req0_a;
      sel_b        = grant1 ? bus.req1_b      : bus.req0_b;
      sel_s        = grant1 ? bus.req1_signed : bus.req0_signed;
      last_grant_d = last_grant_q;
      s1_valid_d   = grant0 | grant1;
      s1_tag_d     = s1_tag_q;
      s1_neg_d     = s1_neg_q;
      s1_a_d       = s1_a_q;
      s1_b_d       = s1_b_q;
      if (grant0 | grant1) begin
         last_grant_d = grant1;
         s1_tag_d     = grant1;
         s1_neg_d     = sel_s & (sel_a[WIDTH-1] ^ sel_b[WIDTH-1]);
         s1_a_d       = magnitude(sel_a, sel_s);
         s1_b_d       = magnitude(sel_b, sel_s);
      end
   end

   mul_array #(
      .WIDTH        (WIDTH),
      .BEHAVIORAL   (0),
      .RIPPLE_CARRY (1)
   ) u_mul (
      .a_i (s1_a_q),
      .b_i (s1_b_q),
      .p_o (prod_u)
   );

   assign prod_s = s1_neg_q ? (~prod_u + PW'(1)) : prod_u;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         last_grant_q   <= 1'b1;
         s1_valid_q     <= 1'b0;
         s1_tag_q       <= 1'b0;
         s1_neg_q       <= 1'b0;
         s1_a_q         <= '0;
         s1_b_q         <= '0;
         resp0_valid_q  <= 1'b0;
         resp1_valid_q  <= 1'b0;
         resp0_result_q <= '0;
         resp1_result_q <= '0;
      end else begin
         last_grant_q  <= last_grant_d;
         s1_valid_q    <= s1_valid_d;
         s1_tag_q      <= s1_tag_d;
         s1_neg_q      <= s1_neg_d;
         s1_a_q        <= s1_a_d;
         s1_b_q        <= s1_b_d;
         resp0_valid_q <= s1_valid_q & ~s1_tag_q;
         resp1_valid_q <= s1_valid_q & s1_tag_q;
         // Only the addressed port's result moves; the other keeps its value.
         if (s1_valid_q && !s1_tag_q) resp0_result_q <= prod_s;
         if (s1_valid_q && s1_tag_q)  resp1_result_q <= prod_s;
      end
   end

   assign bus.resp0_valid  = resp0_valid_q;
   assign bus.resp1_valid  = resp1_valid_q;
   assign bus.resp0_result = resp0_result_q;
   assign bus.resp1_result = resp1_result_q;
endmodule

// File: tb/tb_mul_share_arbiter.sv
module tb_mul_share_arbiter;
   logic clk;
   logic rst;
   int   errors;
   int   checks;

   mul_share_arbiter_if #(.WIDTH(16)) bus ();

   mul_share_arbiter #(.WIDTH(16)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // ---------------- reference model ----------------
   int          m_last;          // requester that won the last accept
   bit          p_val [2];       // [0]: accepted last cycle, [1]: two cycles ago
   int          p_tag [2];
   logic [31:0] p_res [2];
   logic [31:0] m_hold [2];      // value each result port should show

   logic        obs_rdy0, obs_rdy1, obs_v0, obs_v1;
   logic [31:0] obs_res0, obs_res1;
   logic        exp_rdy0, exp_rdy1, exp_v0, exp_v1;
   logic [31:0] exp_res0, exp_res1;

   function automatic logic [31:0] ref_mul(input logic [15:0] a, input logic [15:0] b,
                                           input logic s);
      longint x;
      if (s) x = longint'($signed(a)) * longint'($signed(b));
      else   x = longint'(a) * longint'(b);
      return x[31:0];
   endfunction

   task automatic model_reset();
      m_last = 1;
      for (int i = 0; i < 2; i++) begin
         p_val[i] = 1'b0; p_tag[i] = 0; p_res[i] = '0; m_hold[i] = '0;
      end
   endtask

   // One clock cycle: drive at posedge+1, sample at the falling edge, advance
   // the model, and optionally assert reset mid-cycle (kill).
   task automatic cyc(input logic v0, input logic [15:0] a0, input logic [15:0] b0,
                      input logic s0, input logic v1, input logic [15:0] a1,
                      input logic [15:0] b1, input logic s1, input logic kill);
      int g;
      bus.req0_valid = v0; bus.req0_a = a0; bus.req0_b = b0; bus.req0_signed = s0;
      bus.req1_valid = v1; bus.req1_a = a1; bus.req1_b = b1; bus.req1_signed = s1;
      #4;
      obs_rdy0 = bus.req0_ready;  obs_rdy1 = bus.req1_ready;
      obs_v0   = bus.resp0_valid; obs_v1   = bus.resp1_valid;
      obs_res0 = bus.resp0_result; obs_res1 = bus.resp1_result;
      g = -1;
      if (v0 && !v1)      g = 0;
      else if (v1 && !v0) g = 1;
      else if (v0 && v1)  g = (m_last == 0) ? 1 : 0;
      exp_rdy0 = (g == 0);
      exp_rdy1 = (g == 1);
      exp_v0 = p_val[1] && (p_tag[1] == 0);
      exp_v1 = p_val[1] && (p_tag[1] == 1);
      if (p_val[1]) m_hold[p_tag[1]] = p_res[1];
      exp_res0 = m_hold[0];
      exp_res1 = m_hold[1];
      p_val[1] = p_val[0]; p_tag[1] = p_tag[0]; p_res[1] = p_res[0];
      p_val[0] = (g >= 0);
      p_tag[0] = g;
      p_res[0] = (g == 1) ? ref_mul(a1, b1, s1) : ref_mul(a0, b0, s0);
      if (g >= 0) m_last = g;
      if (kill) begin
         #1 rst = 1'b1;
         model_reset();
      end
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      rst = 1'b1;
      bus.req0_valid = 1'b0; bus.req1_valid = 1'b0;
      @(posedge clk);
      #1 rst = 1'b0;
      model_reset();
   endtask

   // ---------------- tests ----------------
   task automatic test_reset();
      rst = 1'b1;
      bus.req0_valid = 1'b0; bus.req1_valid = 1'b0;
      bus.req0_a = '0; bus.req0_b = '0; bus.req0_signed = 1'b0;
      bus.req1_a = '0; bus.req1_b = '0; bus.req1_signed = 1'b0;
      model_reset();
      @(posedge clk); #1; @(posedge clk); #1;
      checks++;
      if (bus.resp0_valid !== 1'b0 || bus.resp1_valid !== 1'b0) begin
         errors++;
         $display("FAIL reset_valid: got %b%b want 00", bus.resp0_valid, bus.resp1_valid);
      end
      checks++;
      if (bus.resp0_result !== 32'h0 || bus.resp1_result !== 32'h0) begin
         errors++;
         $display("FAIL reset_result: got %h/%h want 0/0", bus.resp0_result, bus.resp1_result);
      end
      checks++;
      if (bus.req0_ready !== 1'b0 || bus.req1_ready !== 1'b0) begin
         errors++;
         $display("FAIL reset_ready: got %b%b want 00", bus.req0_ready, bus.req1_ready);
      end
      $display("reset: resp valid %b%b result %h/%h", bus.resp0_valid, bus.resp1_valid,
               bus.resp0_result, bus.resp1_result);
      rst = 1'b0;
   endtask

   task automatic test_single();
      for (int c = 0; c < 4; c++) begin
         cyc(c == 0, 16'd3, 16'd5, 1'b0, 1'b0, 16'd0, 16'd0, 1'b0, 1'b0);
         checks++;
         if ({obs_rdy0, obs_rdy1} !== {exp_rdy0, exp_rdy1}) begin
            errors++;
            $display("FAIL single_ready c%0d: got %b%b want %b%b", c, obs_rdy0, obs_rdy1, exp_rdy0, exp_rdy1);
         end
         checks++;
         if ({obs_v0, obs_v1} !== {exp_v0, exp_v1}) begin
            errors++;
            $display("FAIL single_valid c%0d: got %b%b want %b%b", c, obs_v0, obs_v1, exp_v0, exp_v1);
         end
         checks++;
         if (obs_res0 !== exp_res0 || obs_res1 !== exp_res1) begin
            errors++;
            $display("FAIL single_result c%0d: got %h/%h want %h/%h", c, obs_res0, obs_res1, exp_res0, exp_res1);
         end
         $display("single c%0d: rdy %b%b resp %b%b %h/%h", c, obs_rdy0, obs_rdy1, obs_v0, obs_v1, obs_res0, obs_res1);
      end
   endtask

   task automatic test_alternate();
      do_reset();
      for (int c = 0; c < 7; c++) begin
         cyc(c < 4, 16'd2, 16'd7, 1'b0, c < 4, 16'd4, 16'd9, 1'b0, 1'b0);
         checks++;
         if ({obs_rdy0, obs_rdy1} !== {exp_rdy0, exp_rdy1}) begin
            errors++;
            $display("FAIL alt_ready c%0d: got %b%b want %b%b", c, obs_rdy0, obs_rdy1, exp_rdy0, exp_rdy1);
         end
         checks++;
         if ({obs_v0, obs_v1} !== {exp_v0, exp_v1}) begin
            errors++;
            $display("FAIL alt_valid c%0d: got %b%b want %b%b", c, obs_v0, obs_v1, exp_v0, exp_v1);
         end
         checks++;
         if (obs_res0 !== exp_res0 || obs_res1 !== exp_res1) begin
            errors++;
            $display("FAIL alt_result c%0d: got %h/%h want %h/%h", c, obs_res0, obs_res1, exp_res0, exp_res1);
         end
         $display("alternate c%0d: rdy %b%b resp %b%b %0d/%0d", c, obs_rdy0, obs_rdy1, obs_v0, obs_v1, obs_res0, obs_res1);
      end
   endtask

   task automatic test_signed();
      logic [15:0] va [4];
      logic [15:0] vb [4];
      logic        vs [4];
      va[0] = 16'hFFFD; vb[0] = 16'd5;    vs[0] = 1'b1;
      va[1] = 16'h8000; vb[1] = 16'h8000; vs[1] = 1'b1;
      va[2] = 16'h8000; vb[2] = 16'd1;    vs[2] = 1'b1;
      va[3] = 16'hFFFF; vb[3] = 16'hFFFF; vs[3] = 1'b0;
      for (int c = 0; c < 6; c++) begin
         cyc(c < 4, va[c % 4], vb[c % 4], vs[c % 4], 1'b0, 16'd0, 16'd0, 1'b0, 1'b0);
         checks++;
         if ({obs_v0, obs_v1} !== {exp_v0, exp_v1}) begin
            errors++;
            $display("FAIL signed_valid c%0d: got %b%b want %b%b", c, obs_v0, obs_v1, exp_v0, exp_v1);
         end
         checks++;
         if (obs_res0 !== exp_res0) begin
            errors++;
            $display("FAIL signed_result c%0d: got %h want %h", c, obs_res0, exp_res0);
         end
         $display("signed c%0d: resp0 %b %h", c, obs_v0, obs_res0);
      end
   endtask

   task automatic test_back_to_back();
      for (int c = 0; c < 12; c++) begin
         cyc(1'b0, 16'd0, 16'd0, 1'b0, c < 10, 16'($urandom), 16'($urandom),
             1'($urandom), 1'b0);
         checks++;
         if ({obs_rdy0, obs_rdy1} !== {exp_rdy0, exp_rdy1}) begin
            errors++;
            $display("FAIL b2b_ready c%0d: got %b%b want %b%b", c, obs_rdy0, obs_rdy1, exp_rdy0, exp_rdy1);
         end
         checks++;
         if ({obs_v0, obs_v1} !== {exp_v0, exp_v1}) begin
            errors++;
            $display("FAIL b2b_valid c%0d: got %b%b want %b%b", c, obs_v0, obs_v1, exp_v0, exp_v1);
         end
         checks++;
         if (obs_res1 !== exp_res1) begin
            errors++;
            $display("FAIL b2b_result c%0d: got %h want %h", c, obs_res1, exp_res1);
         end
         $display("back_to_back c%0d: rdy1 %b resp1 %b %h", c, obs_rdy1, obs_v1, obs_res1);
      end
   endtask

   task automatic test_reset_flush();
      cyc(1'b1, 16'd11, 16'd13, 1'b0, 1'b0, 16'd0, 16'd0, 1'b0, 1'b0);
      cyc(1'b0, 16'd0, 16'd0, 1'b0, 1'b1, 16'd17, 16'd19, 1'b0, 1'b1);
      // reset is now asserted and has been held over one rising edge
      rst = 1'b0;
      for (int c = 0; c < 6; c++) begin
         cyc(c == 4, 16'd6, 16'd6, 1'b0, c == 4, 16'd8, 16'd8, 1'b0, 1'b0);
         checks++;
         if ({obs_rdy0, obs_rdy1} !== {exp_rdy0, exp_rdy1}) begin
            errors++;
            $display("FAIL flush_ready c%0d: got %b%b want %b%b", c, obs_rdy0, obs_rdy1, exp_rdy0, exp_rdy1);
         end
         checks++;
         if ({obs_v0, obs_v1} !== {exp_v0, exp_v1}) begin
            errors++;
            $display("FAIL flush_valid c%0d: got %b%b want %b%b", c, obs_v0, obs_v1, exp_v0, exp_v1);
         end
         checks++;
         if (obs_res0 !== exp_res0 || obs_res1 !== exp_res1) begin
            errors++;
            $display("FAIL flush_result c%0d: got %h/%h want %h/%h", c, obs_res0, obs_res1, exp_res0, exp_res1);
         end
         $display("reset_flush c%0d: rdy %b%b resp %b%b %h/%h", c, obs_rdy0, obs_rdy1, obs_v0, obs_v1, obs_res0, obs_res1);
      end
   endtask

   task automatic test_operand_change();
      for (int c = 0; c < 10; c++) begin
         cyc(c < 8, 16'($urandom), 16'($urandom), 1'($urandom),
             c < 8, 16'd1000, 16'd3, 1'b0, 1'b0);
         checks++;
         if ({obs_rdy0, obs_rdy1} !== {exp_rdy0, exp_rdy1}) begin
            errors++;
            $display("FAIL opchg_ready c%0d: got %b%b want %b%b", c, obs_rdy0, obs_rdy1, exp_rdy0, exp_rdy1);
         end
         checks++;
         if ({obs_v0, obs_v1} !== {exp_v0, exp_v1} || obs_res0 !== exp_res0 || obs_res1 !== exp_res1) begin
            errors++;
            $display("FAIL opchg_resp c%0d: got %b%b %h/%h want %b%b %h/%h", c, obs_v0, obs_v1,
                     obs_res0, obs_res1, exp_v0, exp_v1, exp_res0, exp_res1);
         end
         $display("operand_change c%0d: rdy %b%b resp %b%b %h/%h", c, obs_rdy0, obs_rdy1, obs_v0, obs_v1, obs_res0, obs_res1);
      end
   endtask

   task automatic test_random();
      for (int c = 0; c < 300; c++) begin
         cyc(1'($urandom), 16'($urandom), 16'($urandom), 1'($urandom),
             1'($urandom), 16'($urandom), 16'($urandom), 1'($urandom), 1'b0);
         checks++;
         if ({obs_rdy0, obs_rdy1} !== {exp_rdy0, exp_rdy1}) begin
            errors++;
            $display("FAIL rand_ready c%0d: got %b%b want %b%b", c, obs_rdy0, obs_rdy1, exp_rdy0, exp_rdy1);
         end
         checks++;
         if ({obs_v0, obs_v1} !== {exp_v0, exp_v1} || obs_res0 !== exp_res0 || obs_res1 !== exp_res1) begin
            errors++;
            $display("FAIL rand_resp c%0d: got %b%b %h/%h want %b%b %h/%h", c, obs_v0, obs_v1,
                     obs_res0, obs_res1, exp_v0, exp_v1, exp_res0, exp_res1);
         end
         $display("random c%0d: rdy %b%b resp %b%b %h/%h", c, obs_rdy0, obs_rdy1, obs_v0, obs_v1, obs_res0, obs_res1);
      end
   endtask

   initial begin
      errors = 0;
      checks = 0;
      rst    = 1'b1;
      bus.req0_valid = 1'b0;
      bus.req1_valid = 1'b0;
      @(posedge clk);
      #1;
      test_reset();
      test_single();
      test_alternate();
      test_signed();
      test_back_to_back();
      test_reset_flush();
      test_operand_change();
      test_random();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule

// File: doc/mul_share_arbiter.md
Name: mul_share_arbiter

Overview:
- Shares one combinational array multiplier (mul_array, WIDTH, BEHAVIORAL=0, RIPPLE_CARRY=1) between two requesters.
- Front end: round-robin arbiter with valid/ready handshake.
- Back end: 2-stage pipeline (operand register, product register) that returns a tagged result to the winning requester.
- Adds signed/unsigned operation by magnitude conversion around the unsigned array.
- Sits between the two issuing execution lanes and the shared multiplier resource.

Parameters:
WIDTH, 16, operand width in bits; results are 2*WIDTH bits.

Ports:
clk  input  1  clock, all state on rising edge
rst  input  1  asynchronous, active-high reset
req0_valid  input  1  requester 0 has an operation
req0_ready  output  1  requester 0 operation accepted this cycle
req0_a  input  WIDTH  requester 0 operand A
req0_b  input  WIDTH  requester 0 operand B
req0_signed  input  1  1 = two's-complement operands, 0 = unsigned
req1_valid  input  1  requester 1 has an operation
req1_ready  output  1  requester 1 operation accepted this cycle
req1_a  input  WIDTH  requester 1 operand A
req1_b  input  WIDTH  requester 1 operand B
req1_signed  input  1  requester 1 signedness
resp0_valid  output  1  one-cycle pulse: resp0_result valid
resp0_result  output  2*WIDTH  product for requester 0
resp1_valid  output  1  one-cycle pulse: resp1_result valid
resp1_result  output  2*WIDTH  product for requester 1

Behaviour:
- Reset (async, rst=1):
  - last_grant=1, so requester 0 wins first.
  - Stage-1 and stage-2 valid bits = 0.
  - resp0_valid=resp1_valid=0.
  - resp*_result=0.
  - Operand/tag registers = 0.
- Arbitration (combinational, same cycle):
  - Only req0_valid → req0_ready=1.
  - Only req1_valid → req1_ready=1.
  - Both valid → grant the requester != last_grant.
  - Neither valid → both ready=0.
  - At most one ready high per cycle.
  - Ready never depends on pipeline state; the pipeline accepts one op every cycle.
- Accept = reqN_valid & reqN_ready. On accept, last_grant <= N. No accept → last_grant holds.
- Stage 1, at the edge ending the accept cycle T:
  - Store |A| and |B|. If signed and MSB=1, magnitude = two's-complement negate.
  - -2^(WIDTH-1) maps to 2^(WIDTH-1), which fits unsigned WIDTH.
  - neg = signed & (A[MSB] ^ B[MSB]).
  - Store tag = N and s1_valid=1. No accept → s1_valid=0.
- The mul_array computes the unsigned product of the stage-1 registers combinationally during T+1.
- Stage 2, at the edge ending T+1:
  - Register the product, negated (two's complement, 2*WIDTH bits) if neg.
  - Drive resp<tag>_valid=1 and resp<tag>_result = product.
  - The other resp valid = 0.
- Latency: accept in cycle T → response visible in cycle T+2. Exactly one response per accept, in acceptance order.
- Throughput: one op per cycle. Back-to-back accepts from alternating or the same requester produce back-to-back responses.
- Result when resp valid=0: resp*_result holds its last value. Consumers qualify with valid.
- No response backpressure. Requesters must sink a response in its valid cycle.
- Reset mid-operation: all in-flight ops are discarded. No response pulse follows reset deassertion until a new accept.
- Operands and signedness are sampled only in the accept cycle. Changes while not ready are ignored.
- Unsigned mode: full 2*WIDTH product, no overflow possible. Signed mode: exact 2*WIDTH-bit two's-complement product.

Test Plan:
1. Reset, then req0 alone, unsigned A=3, B=5: req0_ready=1 in cycle T; resp0_valid=1, resp0_result=15 in T+2; resp1_valid=0 throughout.
2. Both valid for 4 cycles after reset, constant operands (r0: 2*7, r1: 4*9): grants 0,1,0,1; responses 14,36,14,36 on alternating resp ports, each 2 cycles after its accept.
3. Signed WIDTH=16:
   - -3*5 → 0xFFFFFFF1
   - -32768*-32768 → 0x40000000
   - -32768*1 → 0xFFFF8000
   - Unsigned 0xFFFF*0xFFFF → 0xFFFE0001
4. req1 valid every cycle, req0 idle: accepts every cycle, resp1_valid continuously high with the correct per-cycle products.
5. Assert rst one cycle after two accepts: last_grant returns to 1; no resp pulse ever appears for the flushed ops; first post-reset simultaneous request grants req0.
6. req0 changes operands while req1 holds the grant: req0 result reflects only the operands present in its accept cycle.
